fifo_wr_arbiter: RTL and testbench

- Shares the write port of one line/pixel FIFO between NUM_REQ pixel sources (e.g. camera, test-pattern, DMA replay).
- Round-robin arbitration at packet granularity: a grant is held from the first beat to the beat flagged last (end of line).
- Drives the FIFO's write enable and write data, and throttles sources from the FIFO occupancy count.
- Sits directly upstream of the FIFO in the image-processing pipeline. Both blocks run on the same clock.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Brief    : Shared types and helpers for the FIFO write-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

   // Arbiter FSM: IDLE picks a source, LOCK forwards its packet.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   // Headroom kept free in the FIFO: one registered write in flight plus
   // the FIFO's own full flag asserting at DEPTH-1.
   localparam int c_occ_margin = 2;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin picker. Searches upward from
//             last_ptr+1 (wrapping) and returns the first requester found,
//             both as a one-hot vector and as an index. With no request the
//             one-hot is zero and idx echoes last_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_ptr,
   output logic [NUM_REQ-1:0] onehot,
   output logic [IDX_W-1:0]   idx
);

   logic             w_found;
   logic [IDX_W-1:0] w_cand;

   // Rotating priority scan; the first hit after last_ptr wins.
   always_comb begin
      onehot  = '0;
      idx     = last_ptr;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(last_ptr) + k) % NUM_REQ);
         if (!w_found && req[w_cand]) begin
            w_found        = 1'b1;
            onehot[w_cand] = 1'b1;
            idx            = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Shares one FIFO write port between NUM_REQ pixel sources with
//             packet-granular round-robin arbitration. A grant is held from
//             the first beat to the beat flagged last; sources are throttled
//             from the FIFO occupancy so the FIFO never overflows.
//             Write enable and data are registered (1-cycle latency).
//  Options  : ARB_MAX_BURST_EN - when defined, a grant is also ended after
//             MAX_BURST beats and the remainder of the packet continues at
//             the source's next grant.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 1 << ADDR_WIDTH,
   parameter int MAX_BURST  = 64
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                s_valid,
   input  logic [NUM_REQ-1:0]                s_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_data,
   output logic [NUM_REQ-1:0]                s_ready,
   input  logic [ADDR_WIDTH:0]               fifo_occupants,
   output logic                              fifo_we,
   output logic [DATA_WIDTH-1:0]             fifo_wdata,
   output logic [clog2_min1(NUM_REQ)-1:0]    grant_id,
   output logic                              busy
);

   localparam int                  c_gw          = clog2_min1(NUM_REQ);
   localparam logic [ADDR_WIDTH:0] c_space_limit = (ADDR_WIDTH+1)'(FIFO_DEPTH - c_occ_margin);

   arb_state_t              state_q, state_d;
   logic [c_gw-1:0]         grant_q, grant_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

   logic                    w_space;
   logic                    w_xfer;
   logic                    w_any_req;
   logic                    w_burst_done;
   logic [NUM_REQ-1:0]      w_pick_onehot;
   logic [c_gw-1:0]         w_pick_idx;

   assign w_space   = (fifo_occupants < c_space_limit);
   assign w_any_req = |w_pick_onehot;
   assign w_xfer    = s_valid[grant_q] & s_ready[grant_q];

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_gw)
   ) u_pick (
      .req      (s_valid),
      .last_ptr (grant_q),
      .onehot   (w_pick_onehot),
      .idx      (w_pick_idx)
   );

`ifdef ARB_MAX_BURST_EN
   localparam int c_burst_w = clog2_min1(MAX_BURST);

   logic [c_burst_w-1:0] burst_q, burst_d;

   // Beat counter: held at zero while idle so every grant starts from zero.
   always_comb begin
      burst_d      = burst_q;
      w_burst_done = 1'b0;
      if (state_q == IDLE) begin
         burst_d = '0;
      end else if (w_xfer) begin
         if (burst_q == c_burst_w'(MAX_BURST - 1)) begin
            w_burst_done = 1'b1;
            burst_d      = '0;
         end else begin
            burst_d = burst_q + c_burst_w'(1);
         end
      end
   end

   // Beat counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end
`else
   // No burst limit in this build: a grant lasts until the last beat.
   logic unused_max_burst;
   assign w_burst_done     = 1'b0;
   assign unused_max_burst = (MAX_BURST != 0);
`endif

   // State, grant pointer and registered FIFO write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= c_gw'(NUM_REQ - 1);
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   // Next state: arbitrate in IDLE, forward beats and watch for packet end in LOCK.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      we_d    = 1'b0;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (w_any_req) begin
               grant_d = w_pick_idx;
               state_d = LOCK;
            end
         end
         LOCK: begin
            if (w_xfer) begin
               we_d    = 1'b1;
               wdata_d = s_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
               if (s_last[grant_q] || w_burst_done) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: only the granted source sees ready, and only while the FIFO has room.
   always_comb begin
      s_ready = '0;
      busy    = (state_q == LOCK);
      if (state_q == LOCK) begin
         s_ready[grant_q] = w_space;
      end
   end

   assign fifo_we    = we_q;
   assign fifo_wdata = wdata_q;
   assign grant_id   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Self-checking bench for fifo_wr_arbiter. Sources are packet
//             queues; a packet-level reference model predicts ownership,
//             ready, and the FIFO write stream each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int MB    = 4;
   localparam int GW    = 2;

   logic               clk;
   logic               rst;
   logic [NR-1:0]      s_valid;
   logic [NR-1:0]      s_last;
   logic [NR*DW-1:0]   s_data;
   logic [NR-1:0]      s_ready;
   logic [AW:0]        fifo_occupants;
   logic               fifo_we;
   logic [DW-1:0]      fifo_wdata;
   logic [GW-1:0]      grant_id;
   logic               busy;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .FIFO_DEPTH (DEPTH),
      .MAX_BURST  (MB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_last         (s_last),
      .s_data         (s_data),
      .s_ready        (s_ready),
      .fifo_occupants (fifo_occupants),
      .fifo_we        (fifo_we),
      .fifo_wdata     (fifo_wdata),
      .grant_id       (grant_id),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Source beat queues: {last, data}
   logic [DW:0] src_q [NR][$];
   int          hold  [NR];
   int          exp_q [$];
   int          wlog  [$];
   int          glog  [$];
   int          gaplog[$];

   // Reference model: owner < 0 means nobody holds the write port.
   int m_owner = -1;
   int m_ptr   = NR - 1;
   int m_we    = 0;
   int m_wdata = 0;
   int m_cnt   = 0;

   int rst_req   = 0;
   int vprob     = 100;
   int occ_val   = 0;
   int prev_busy = 0;
   int idle_run  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pending();
      int p = exp_q.size() + ((m_owner >= 0) ? 1 : 0) + m_we;
      for (int i = 0; i < NR; i++) p += src_q[i].size();
      return p;
   endfunction

   task automatic load_pkt(input int src, input int len, input int base, input bit rnd);
      for (int b = 0; b < len; b++) begin
         logic [DW-1:0] d;
         d = rnd ? DW'($urandom) : DW'(base + b);
         src_q[src].push_back({(b == len - 1), d});
      end
   endtask

   // One clock: check registered outputs, drive inputs, check ready, advance model.
   task automatic cycle();
      logic [NR-1:0] exp_ready;
      int            space;
      int            g;
      @(negedge clk);
      chk("fifo_we",    int'(fifo_we),    m_we);
      chk("fifo_wdata", int'(fifo_wdata), m_wdata);
      chk("grant_id",   int'(grant_id),   m_ptr);
      chk("busy",       int'(busy),       (m_owner >= 0) ? 1 : 0);
      if (fifo_we) begin
         wlog.push_back(int'(fifo_wdata));
         if (exp_q.size() == 0) chk("sb_count", exp_q.size(), 1);
         else                   chk("sb_data", int'(fifo_wdata), exp_q.pop_front());
      end
      if (busy && prev_busy == 0) begin
         glog.push_back(int'(grant_id));
         gaplog.push_back(idle_run);
      end
      idle_run  = busy ? 0 : idle_run + 1;
      prev_busy = int'(busy);

      rst = (rst_req != 0);
      for (int i = 0; i < NR; i++) begin
         bit en;
         en = (src_q[i].size() > 0) && (hold[i] == 0) && ($urandom_range(99) < vprob);
         if (hold[i] > 0) hold[i]--;
         s_valid[i]          = en;
         s_last[i]           = en ? src_q[i][0][DW] : 1'b0;
         s_data[i*DW +: DW]  = en ? src_q[i][0][DW-1:0] : DW'($urandom);
      end
      fifo_occupants = (AW+1)'(occ_val);
      #1;

      space = (occ_val < DEPTH - 2) ? 1 : 0;
      if (rst) begin
         m_owner = -1; m_ptr = NR - 1; m_we = 0; m_wdata = 0; m_cnt = 0;
         for (int i = 0; i < NR; i++) src_q[i].delete();
         exp_q.delete();
      end else begin
         exp_ready = '0;
         if (m_owner >= 0 && space != 0) exp_ready[m_owner] = 1'b1;
         chk("s_ready", int'(s_ready), int'(exp_ready));
         m_we = 0;
         if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
               g = (m_ptr + k) % NR;
               if (m_owner < 0 && s_valid[g]) begin
                  m_owner = g;
                  m_cnt   = 0;
               end
            end
            if (m_owner >= 0) m_ptr = m_owner;
         end else begin
            g = m_owner;
            if (s_valid[g] && space != 0) begin
               logic [DW:0] beat;
               beat    = src_q[g].pop_front();
               m_we    = 1;
               m_wdata = int'(beat[DW-1:0]);
               exp_q.push_back(m_wdata);
               m_cnt++;
               if (beat[DW]) m_owner = -1;
`ifdef ARB_MAX_BURST_EN
               if (m_cnt == MB) m_owner = -1;
`endif
            end
         end
      end
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (pending() != 0 && n < 3000) begin
         cycle();
         n++;
      end
      cycle();
      cycle();
      chk(tag, pending(), 0);
   endtask

   task automatic wait_src(input string tag, input int src, input int left);
      int n = 0;
      while (src_q[src].size() > left && n < 200) begin
         cycle();
         n++;
      end
      chk(tag, src_q[src].size(), left);
   endtask

   task automatic reset_pulse();
      rst_req = 1;
      cycle();
      cycle();
      rst_req = 0;
      chk("rst_we",    int'(fifo_we),  0);
      chk("rst_busy",  int'(busy),     0);
      chk("rst_grant", int'(grant_id), NR - 1);
      chk("rst_ready", int'(s_ready),  0);
      chk("rst_wdata", int'(fifo_wdata), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      s_valid        = '0;
      s_last         = '0;
      s_data         = '0;
      fifo_occupants = '0;
      for (int i = 0; i < NR; i++) hold[i] = 0;

      // Single 4-beat packet from source 0.
      reset_pulse();
      wlog.delete(); glog.delete();
      load_pkt(0, 4, 'h10, 0);
      drain("p1_drain");
      chk("p1_nwrites", wlog.size(), 4);
      for (int k = 0; k < 4; k++) chk("p1_data", wlog[k], 'h10 + k);
      chk("p1_grant", glog[0], 0);

      // Three sources with 2-beat packets: round robin with one idle bubble.
      reset_pulse();
      wlog.delete(); glog.delete(); gaplog.delete();
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 3; s++) load_pkt(s, 2, 'h50 + 16*s + 2*r, 0);
      drain("p2_drain");
      chk("p2_ngrants", glog.size(), 6);
      chk("p2_order0", glog[0], 0);
      chk("p2_order1", glog[1], 1);
      chk("p2_order2", glog[2], 2);
      chk("p2_order3", glog[3], 0);
      for (int k = 1; k < 4; k++) chk("p2_bubble", gaplog[k], 1);

      // FIFO near full mid-packet stalls, then resumes losslessly.
      wlog.delete();
      load_pkt(0, 5, 'h20, 0);
      wait_src("p3_wait", 0, 3);
      occ_val = DEPTH - 2;
      repeat (4) cycle();
      occ_val = DEPTH - 3;
      drain("p3_drain");
      occ_val = 0;
      chk("p3_nwrites", wlog.size(), 5);
      for (int k = 0; k < 5; k++) chk("p3_data", wlog[k], 'h20 + k);

      // Reset on the 2nd beat of a 5-beat packet.
      load_pkt(0, 5, 'h30, 0);
      wait_src("p4_wait", 0, 4);
      rst_req = 1;
      cycle();
      rst_req = 0;
      @(posedge clk); #1;
      chk("p4_we",    int'(fifo_we),  0);
      chk("p4_busy",  int'(busy),     0);
      chk("p4_grant", int'(grant_id), NR - 1);
      glog.delete();
      load_pkt(2, 2, 'h60, 0);
      load_pkt(0, 2, 'h70, 0);
      drain("p4_drain");
      chk("p4_first", glog[0], 0);

      // Source 3 pauses mid-packet; source 1 must wait for its last beat.
      reset_pulse();
      glog.delete(); wlog.delete();
      load_pkt(3, 4, 'hA0, 0);
      wait_src("p5_wait", 3, 3);
      hold[3] = 3;
      load_pkt(1, 2, 'hB0, 0);
      drain("p5_drain");
      chk("p5_ngrants", glog.size(), 2);
      chk("p5_g0", glog[0], 3);
      chk("p5_g1", glog[1], 1);
      chk("p5_w4", wlog[4], 'hB0);

`ifdef ARB_MAX_BURST_EN
      // Long packet split at MAX_BURST, other source slots in between.
      reset_pulse();
      glog.delete(); wlog.delete();
      load_pkt(0, 10, 'h40, 0);
      load_pkt(1, 3, 'h80, 0);
      drain("pb_drain");
      chk("pb_g0", glog[0], 0);
      chk("pb_g1", glog[1], 1);
      chk("pb_g2", glog[2], 0);
      chk("pb_nwrites", wlog.size(), 13);
      for (int k = 0; k < 4; k++)  chk("pb_a", wlog[k], 'h40 + k);
      for (int k = 0; k < 3; k++)  chk("pb_b", wlog[4 + k], 'h80 + k);
      for (int k = 0; k < 6; k++)  chk("pb_c", wlog[7 + k], 'h44 + k);
`endif

      // Randomized traffic with occupancy around the threshold and rare resets.
      reset_pulse();
      vprob = 75;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(99) < 15) begin
            int s;
            s = int'($urandom_range(NR - 1));
            if (src_q[s].size() < 24) load_pkt(s, int'($urandom_range(1, 10)), 0, 1);
         end
         for (int i = 0; i < NR; i++)
            if ($urandom_range(99) < 2) hold[i] = int'($urandom_range(1, 4));
         occ_val = ($urandom_range(1) != 0) ? int'($urandom_range(DEPTH - 4))
                                            : int'($urandom_range(DEPTH - 4, DEPTH));
         rst_req = ($urandom_range(999) == 0) ? 1 : 0;
         cycle();
      end
      rst_req = 0;
      occ_val = 0;
      vprob   = 100;
      drain("rand_drain");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
